// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if
//   Bundles the stage-change request inputs and the sequencer status outputs.
//   master : active stage logic (drives flag/select, observes status)
//   slave  : stage_sequencer    (consumes flag/select, drives status)
//   Signals:
//     next_stage_flag [2:0] : 001 ADVANCE, 010 GAMEOVER, 100 RESTART, others ignored
//     stage_select    [1:0] : menu choice, used on ADVANCE from OPENING
//     cur_stage       [2:0] : 000 OPENING, 001..011 STAGE1..3, 100 FINISH
//     blank                 : high while a stage change is in progress
//     stage_start           : one-cycle pulse when cur_stage takes a new value
//     clear_count     [1:0] : stages cleared in the current game (saturates at 3)
interface stage_sequencer_if;
    logic [2:0] next_stage_flag;
    logic [1:0] stage_select;
    logic [2:0] cur_stage;
    logic       blank;
    logic       stage_start;
    logic [1:0] clear_count;

    modport master (
        output next_stage_flag, stage_select,
        input  cur_stage, blank, stage_start, clear_count
    );

    modport slave (
        input  next_stage_flag, stage_select,
        output cur_stage, blank, stage_start, clear_count
    );
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Sequences the game through OPENING -> STAGE1..3 -> FINISH. A request seen
//   in RUN latches its destination, then the block blanks for TRANS_CYCLES
//   cycles, switches cur_stage with a one-cycle stage_start pulse, and holds a
//   2-cycle GUARD window that swallows stale flags before sampling again.
//   Requests arriving during TRANS or GUARD are dropped.
//   Parameters:
//     TRANS_CYCLES   : blanking cycles per stage change (1..255)
//     FINISH_TIMEOUT : idle RUN cycles in FINISH before auto-restart (1..65535)
//   Ports:
//     clk   : system clock
//     reset : asynchronous, active-low reset
//     bus   : stage_sequencer_if.slave (flag/select in, status out)
//   Build option:
//     STAGE_SEQUENCER_TIMEOUT_EN : when defined, an idle counter in FINISH
//     issues an internal RESTART after FINISH_TIMEOUT cycles. An external
//     request in the same cycle takes priority.
module stage_sequencer #(
    parameter int TRANS_CYCLES   = 16,
    parameter int FINISH_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    stage_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {RUN, TRANS, GUARD} state_t;

    localparam logic [2:0] OPENING = 3'd0;
    localparam logic [2:0] STAGE1  = 3'd1;
    localparam logic [2:0] STAGE2  = 3'd2;
    localparam logic [2:0] STAGE3  = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;

    localparam logic [2:0] FLAG_ADV  = 3'b001;
    localparam logic [2:0] FLAG_OVER = 3'b010;
    localparam logic [2:0] FLAG_RST  = 3'b100;

    localparam logic [7:0] TRANS_LAST = 8'(TRANS_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt;          // remaining cycles of TRANS / GUARD, counts to 0
    logic [2:0] stage_q;
    logic [2:0] dest_q;
    logic       inc_q;        // pending change is an ADVANCE out of STAGE1..3
    logic [1:0] clear_q;

    logic       ext_ok;
    logic [2:0] ext_dest;
    logic       ext_inc;
    logic       req_ok;
    logic [2:0] req_dest;
    logic       req_inc;

    // Request decode against the current stage; gated by RUN further down.
    always_comb begin
        ext_ok   = 1'b0;
        ext_dest = stage_q;
        ext_inc  = 1'b0;
        case (bus.next_stage_flag)
            FLAG_ADV: begin
                ext_ok = 1'b1;
                case (stage_q)
                    OPENING: ext_dest = (bus.stage_select == 2'd3) ? STAGE3
                                                                   : STAGE1 + {1'b0, bus.stage_select};
                    STAGE1:  begin ext_dest = STAGE2; ext_inc = 1'b1; end
                    STAGE2:  begin ext_dest = STAGE3; ext_inc = 1'b1; end
                    STAGE3:  begin ext_dest = FINISH; ext_inc = 1'b1; end
                    FINISH:  ext_dest = OPENING;
                    default: ext_ok = 1'b0;
                endcase
            end
            FLAG_OVER: begin
                if (stage_q == STAGE1 || stage_q == STAGE2 || stage_q == STAGE3) begin
                    ext_ok   = 1'b1;
                    ext_dest = FINISH;
                end
            end
            FLAG_RST: begin
                ext_ok   = 1'b1;
                ext_dest = OPENING;
            end
            default: ;
        endcase
    end

`ifdef STAGE_SEQUENCER_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_fire;

    assign to_fire  = (state == RUN) && (stage_q == FINISH) &&
                      (to_cnt == 16'(FINISH_TIMEOUT - 1));
    // External request wins; a lone timeout behaves as RESTART.
    assign req_ok   = ext_ok | to_fire;
    assign req_dest = ext_ok ? ext_dest : OPENING;
    assign req_inc  = ext_ok & ext_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            to_cnt <= '0;
        else if (bus.stage_start)
            to_cnt <= '0;
        else if (state == RUN && stage_q == FINISH && !req_ok)
            to_cnt <= to_cnt + 16'd1;
    end
`else
    assign req_ok   = ext_ok;
    assign req_dest = ext_dest;
    assign req_inc  = ext_inc;
`endif

    // State register plus its phase counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                RUN:     cnt <= TRANS_LAST;
                TRANS:   cnt <= (cnt == 8'd0) ? 8'd1 : cnt - 8'd1;  // GUARD is 2 cycles
                GUARD:   cnt <= (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
                default: cnt <= '0;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (req_ok)      state_nxt = TRANS;
            TRANS:   if (cnt == 8'd0) state_nxt = GUARD;
            GUARD:   if (cnt == 8'd0) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Outputs decoded from state; stage_start is the first GUARD cycle,
    // which is exactly the cycle the new stage_q becomes visible.
    always_comb begin
        bus.blank       = (state == TRANS);
        bus.stage_start = (state == GUARD) && (cnt == 8'd1);
    end

    // Destination latch, stage register and clear counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= OPENING;
            dest_q  <= OPENING;
            inc_q   <= 1'b0;
            clear_q <= '0;
        end else begin
            if (state == RUN && req_ok) begin
                dest_q <= req_dest;
                inc_q  <= req_inc;
            end
            if (state == TRANS && cnt == 8'd0) begin
                stage_q <= dest_q;
                if (dest_q == OPENING)
                    clear_q <= '0;
                else if (inc_q && clear_q != 2'd3)
                    clear_q <= clear_q + 2'd1;
            end
        end
    end

    assign bus.cur_stage   = stage_q;
    assign bus.clear_count = clear_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer
//   Drives stage_sequencer with a table of single requests, hand-written
//   sequences for held flags, mid-blank reset and FINISH idling, and random
//   flags. A cycle-numbered reference model predicts every output each cycle:
//   a request accepted at cycle n blanks n+1..n+T, lands at n+T+1, and the
//   next request can be accepted from n+T+3.
module tb_stage_sequencer;
    localparam int T  = 4;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stage_sequencer_if bus ();

    stage_sequencer #(.TRANS_CYCLES(T), .FINISH_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] flag;
        logic [1:0] sel;
        logic [2:0] stage;
        logic [1:0] clr;
        int         starts;
    } row_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    int k;
    int req_cyc;
    int m_stage, m_dest, m_clear, m_idle;
    bit m_inc;
    int n_blank, n_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0d expected %0d", name, k, act, exp);
        end
    endtask

    task automatic decode(input int stage, input logic [2:0] flag, input int sel,
                          output bit ok, output int dest, output bit inc);
        ok = 0; dest = stage; inc = 0;
        if (flag == 3'b001) begin
            ok  = 1;
            inc = (stage >= 1 && stage <= 3);
            if (stage == 0)      dest = (sel + 1 > 3) ? 3 : sel + 1;
            else if (stage == 4) dest = 0;
            else                 dest = stage + 1;
        end else if (flag == 3'b010) begin
            if (stage >= 1 && stage <= 3) begin ok = 1; dest = 4; end
        end else if (flag == 3'b100) begin
            ok = 1; dest = 0;
        end
    endtask

    task automatic model_reset();
        k = 0; req_cyc = -1000; m_stage = 0; m_clear = 0; m_idle = 0;
        m_dest = 0; m_inc = 0;
    endtask

    // Called at a negedge: drive inputs for cycle k, predict acceptance,
    // move to the next negedge and compare cycle k+1 outputs.
    task automatic step(input logic [2:0] flag, input logic [1:0] sel);
        bit ok, inc;
        int dest;
        bit e_blank, e_start;
        bus.next_stage_flag = flag;
        bus.stage_select    = sel;
        if (k > req_cyc + T + 2) begin
            decode(m_stage, flag, int'(sel), ok, dest, inc);
`ifdef STAGE_SEQUENCER_TIMEOUT_EN
            if (m_stage == 4 && !ok) begin
                m_idle++;
                if (m_idle == TO) begin ok = 1; dest = 0; inc = 0; end
            end
`endif
            if (ok) begin req_cyc = k; m_dest = dest; m_inc = inc; end
        end
        @(negedge clk);
        k++;
        e_start = (k == req_cyc + T + 1);
        if (e_start) begin
            m_stage = m_dest;
            if (m_dest == 0)              m_clear = 0;
            else if (m_inc && m_clear < 3) m_clear++;
            m_idle = 0;
        end
        e_blank = (k > req_cyc) && (k <= req_cyc + T);
        chk("cur_stage",   32'(bus.cur_stage),   32'(m_stage));
        chk("blank",       32'(bus.blank),       32'(e_blank));
        chk("stage_start", 32'(bus.stage_start), 32'(e_start));
        chk("clear_count", 32'(bus.clear_count), 32'(m_clear));
        n_blank += int'(bus.blank);
        n_start += int'(bus.stage_start);
    endtask

    task automatic apply_req(input logic [2:0] flag, input logic [1:0] sel);
        step(flag, sel);
        repeat (T + 2) step(3'b000, 2'd0);
    endtask

    row_t rows[24];
    int   first;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0]  = '{3'b001, 2'd2, 3'd3, 2'd0, 1};   // OPENING ADV sel 2 -> STAGE3
        rows[1]  = '{3'b100, 2'd0, 3'd0, 2'd0, 1};
        rows[2]  = '{3'b010, 2'd0, 3'd0, 2'd0, 0};   // GAMEOVER ignored in OPENING
        rows[3]  = '{3'b011, 2'd1, 3'd0, 2'd0, 0};
        rows[4]  = '{3'b111, 2'd1, 3'd0, 2'd0, 0};
        rows[5]  = '{3'b101, 2'd1, 3'd0, 2'd0, 0};
        rows[6]  = '{3'b110, 2'd1, 3'd0, 2'd0, 0};
        rows[7]  = '{3'b001, 2'd0, 3'd1, 2'd0, 1};
        rows[8]  = '{3'b001, 2'd3, 3'd2, 2'd1, 1};   // select ignored outside OPENING
        rows[9]  = '{3'b010, 2'd0, 3'd4, 2'd1, 1};   // GAMEOVER keeps clear_count
        rows[10] = '{3'b010, 2'd0, 3'd4, 2'd1, 0};   // GAMEOVER ignored in FINISH
        rows[11] = '{3'b001, 2'd0, 3'd0, 2'd0, 1};
        rows[12] = '{3'b001, 2'd3, 3'd3, 2'd0, 1};   // select 3 saturates
        rows[13] = '{3'b001, 2'd0, 3'd4, 2'd1, 1};
        rows[14] = '{3'b100, 2'd0, 3'd0, 2'd0, 1};
        rows[15] = '{3'b100, 2'd0, 3'd0, 2'd0, 1};   // RESTART in OPENING still blanks
        rows[16] = '{3'b001, 2'd0, 3'd1, 2'd0, 1};
        rows[17] = '{3'b001, 2'd0, 3'd2, 2'd1, 1};
        rows[18] = '{3'b001, 2'd0, 3'd3, 2'd2, 1};
        rows[19] = '{3'b001, 2'd0, 3'd4, 2'd3, 1};
        rows[20] = '{3'b001, 2'd1, 3'd0, 2'd0, 1};
        rows[21] = '{3'b001, 2'd1, 3'd2, 2'd0, 1};
        rows[22] = '{3'b010, 2'd0, 3'd4, 2'd0, 1};
        rows[23] = '{3'b100, 2'd0, 3'd0, 2'd0, 1};

        model_reset();
        bus.next_stage_flag = 3'b000;
        bus.stage_select    = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_stage", 32'(bus.cur_stage),   32'd0);
        chk("rst_blank", 32'(bus.blank),       32'd0);
        chk("rst_start", 32'(bus.stage_start), 32'd0);
        chk("rst_clear", 32'(bus.clear_count), 32'd0);
        reset = 1'b1;
        model_reset();

        // table of single requests, each followed by a full change window
        foreach (rows[i]) begin
            n_blank = 0; n_start = 0;
            apply_req(rows[i].flag, rows[i].sel);
            chk($sformatf("row%0d_stage", i), 32'(bus.cur_stage),   32'(rows[i].stage));
            chk($sformatf("row%0d_clear", i), 32'(bus.clear_count), 32'(rows[i].clr));
            chk($sformatf("row%0d_start", i), 32'(n_start),         32'(rows[i].starts));
            chk($sformatf("row%0d_blank", i), 32'(n_blank),         32'(rows[i].starts * T));
        end

        // ADVANCE held from OPENING: one change per 7-cycle window
        n_start = 0;
        repeat (21) step(3'b001, 2'd0);
        chk("held_starts", 32'(n_start), 32'd3);
        repeat (T + 3) step(3'b000, 2'd0);
        chk("held_stage", 32'(bus.cur_stage),   32'd3);
        chk("held_clear", 32'(bus.clear_count), 32'd2);

        // reset asserted during the second blank cycle
        step(3'b001, 2'd0);
        step(3'b000, 2'd0);
        chk("pre_rst_blank", 32'(bus.blank), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_stage", 32'(bus.cur_stage),   32'd0);
        chk("mid_rst_blank", 32'(bus.blank),       32'd0);
        chk("mid_rst_start", 32'(bus.stage_start), 32'd0);
        chk("mid_rst_clear", 32'(bus.clear_count), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        n_start = 0;
        repeat (T + 4) step(3'b000, 2'd0);
        chk("post_rst_starts", 32'(n_start), 32'd0);

        // idle in FINISH
        apply_req(3'b001, 2'd2);
        apply_req(3'b001, 2'd0);
        chk("fin_reached", 32'(bus.cur_stage), 32'd4);
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            step(3'b000, 2'd0);
            if (bus.blank && first == 0) first = i + 1;
        end
`ifdef STAGE_SEQUENCER_TIMEOUT_EN
        chk("to_first_blank", 32'(first),           32'(TO + 1));
        chk("to_stage",       32'(bus.cur_stage),   32'd0);
`else
        chk("fin_no_blank",   32'(first),           32'd0);
        chk("fin_holds",      32'(bus.cur_stage),   32'd4);
`endif

        // RESTART on the cycle the timeout would fire: a single change
        apply_req(3'b100, 2'd0);
        apply_req(3'b001, 2'd2);
        apply_req(3'b001, 2'd0);
        n_blank = 0; n_start = 0;
        repeat (TO - 1) step(3'b000, 2'd0);
        step(3'b100, 2'd0);
        repeat (15) step(3'b000, 2'd0);
        chk("coll_starts", 32'(n_start),         32'd1);
        chk("coll_blank",  32'(n_blank),         32'(T));
        chk("coll_stage",  32'(bus.cur_stage),   32'd0);

        // random flags against the model
        for (int i = 0; i < 500; i++) begin
            int r;
            logic [2:0] f;
            r = $urandom_range(0, 9);
            case (r)
                6:       f = 3'b001;
                7:       f = 3'b010;
                8:       f = 3'b100;
                9:       f = 3'($urandom_range(0, 7));
                default: f = 3'b000;
            endcase
            step(f, 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
